mult_signed_seq_ctrl: RTL

Iterative controller that sequences a shared shift-add signed multiplier datapath over WIDTH cycles, one multiplier bit per cycle.
- Accepts a two's-complement operand pair through a valid/ready handshake.
- Accumulates sign-extended partial products; the MSB partial product is subtracted because it carries negative weight.
- Returns the 2*WIDTH-bit signed product through a second valid/ready handshake.
- Sits between arithmetic clients and the multiplier datapath, replacing the combinational array form where area matters.

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_pp_gen.sv | 27 ++
 rtl/mult_signed_seq_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and width helpers for the sequential signed multiplier.
// Optional early termination is enabled by defining MULT_EARLY_TERM_EN.
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/mult_pp_gen.sv
// Partial-product generator: shifted sign-extended multiplicand,
// negated for the multiplier MSB, or zero when the multiplier bit is clear.
module mult_pp_gen
  import mult_pkg::*;
#(
  parameter int WIDTH = 3,
  localparam int PROD_W = prod_w(WIDTH),
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic [WIDTH-1:0]  a_r,
  input  logic              b_bit,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              is_msb,
  output logic [PROD_W-1:0] pp
);

  logic [PROD_W-1:0] sh;

  always_comb begin
    sh = {{WIDTH{a_r[WIDTH-1]}}, a_r} << cnt;
    pp = '0;
    if (b_bit) begin
      pp = is_msb ? (~sh + 1'b1) : sh;
    end
  end

endmodule

// File: rtl/mult_signed_seq_ctrl.sv
// Iterative shift-add signed multiplier controller, one multiplier bit
// per cycle. MULT_EARLY_TERM_EN skips trailing zero multiplier bits.
module mult_signed_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 3,
  localparam int PROD_W = prod_w(WIDTH),
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] prod,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fin_q, fin_d;

  logic              is_msb;
  logic              rem_zero;
  logic [PROD_W-1:0] pp;

  assign is_msb = (cnt_q == CNT_W'(WIDTH - 1));

  mult_pp_gen #(
    .WIDTH (WIDTH)
  ) u_pp (
    .a_r    (a_q),
    .b_bit  (b_q[cnt_q]),
    .cnt    (cnt_q),
    .is_msb (is_msb),
    .pp     (pp)
  );

  // High when no set multiplier bit lies above the current one.
  always_comb begin
`ifdef MULT_EARLY_TERM_EN
    rem_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (i > int'(cnt_q) && b_q[i]) rem_zero = 1'b0;
    end
`else
    rem_zero = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          fin_d   = 1'b0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (fin_q) begin
          prod_d  = acc_q;
          state_d = S_DONE;
        end else begin
          acc_d = acc_q + pp;
          if (is_msb || rem_zero) fin_d = 1'b1;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign prod      = prod_q;

endmodule
